// File: rtl/full_half_sub_4b.sv
// Registered ripple-borrow subtractor: diff = a - b - cin, borrow = a < b + cin.
// Each bit slice is a full subtractor built from two half subtractors.

module full_half_sub_4b_hs (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_half_sub_4b_fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic bo1;
  logic bo2;

  full_half_sub_4b_hs hs1 (
    .x  (x),
    .y  (y),
    .d  (d1),
    .bo (bo1)
  );

  full_half_sub_4b_hs hs2 (
    .x  (d1),
    .y  (bin),
    .d  (d),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;
endmodule

module full_half_sub_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
);
  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] diff_c;

  assign bchain[0] = cin;

  // Pure ripple chain: bit i's borrow-out is bit i+1's borrow-in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_half_sub_4b_fs fs (
      .x    (a[i]),
      .y    (b[i]),
      .bin  (bchain[i]),
      .d    (diff_c[i]),
      .bout (bchain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      borrow    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= diff_c;
        borrow <= bchain[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_full_half_sub_4b.sv
// Directed bench for full_half_sub_4b (WIDTH = 4) with immediate-assertion checks.

module tb_full_half_sub_4b;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] diff;
  logic       borrow;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_half_sub_4b #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .diff      (diff),
    .borrow    (borrow),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ed, input logic eb, input logic ev);
    check({tag, ".diff"}, {28'b0, diff}, {28'b0, ed});
    check({tag, ".borrow"}, {31'b0, borrow}, {31'b0, eb});
    check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
  endtask

  initial begin
    logic [4:0] ref_v;
    logic [3:0] pa, pb;
    logic       pc;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a = '0; b = '0; cin = 1'b0;

    // Reset held for 3 cycles with random inputs offered
    repeat (3) begin
      @(negedge clk);
      a   = 4'($urandom);
      b   = 4'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
      check_out("reset", 4'h0, 1'b0, 1'b0);
    end

    // Release between edges; nothing captured yet
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'b1001; b = 4'b0100; cin = 1'b0;
    #1;
    check_out("post_release", 4'h0, 1'b0, 1'b0);

    @(negedge clk);
    check_out("9-4", 4'b0101, 1'b0, 1'b1);
    a = 4'b0011; b = 4'b0101; cin = 1'b0;

    @(negedge clk);
    check_out("3-5", 4'b1110, 1'b1, 1'b1);
    a = 4'b0000; b = 4'b0000; cin = 1'b1;

    @(negedge clk);
    check_out("0-0-1", 4'b1111, 1'b1, 1'b1);
    a = 4'b1111; b = 4'b1110; cin = 1'b1;

    @(negedge clk);
    check_out("F-E-1", 4'b0000, 1'b0, 1'b1);
    a = 4'b1111; b = 4'b1111; cin = 1'b1;

    @(negedge clk);
    check_out("F-F-1", 4'b1111, 1'b1, 1'b1);
    a = 4'b0110; b = 4'b0110; cin = 1'b0;

    @(negedge clk);
    check_out("6-6", 4'b0000, 1'b0, 1'b1);
    a = 4'b0000; b = 4'b1111; cin = 1'b1;

    @(negedge clk);
    check_out("wrap", 4'b0000, 1'b1, 1'b1);
    a = 4'b1010; b = 4'b0011; cin = 1'b0;

    @(negedge clk);
    check_out("A-3", 4'b0111, 1'b0, 1'b1);
    in_valid = 1'b0;
    a = 4'b0001; b = 4'b1000; cin = 1'b1;

    @(negedge clk);
    check_out("hold1", 4'b0111, 1'b0, 1'b0);
    a = 4'b1100; b = 4'b0001; cin = 1'b0;

    @(negedge clk);
    check_out("hold2", 4'b0111, 1'b0, 1'b0);
    in_valid = 1'b1;

    // Asynchronous reset well before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'h0, 1'b0, 1'b0);

    @(negedge clk);
    check_out("rst_discard", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Exhaustive back-to-back sweep against the arithmetic reference
    pa = '0; pb = '0; pc = 1'b0;
    for (int unsigned k = 0; k < 512; k++) begin
      a   = k[3:0];
      b   = k[7:4];
      cin = k[8];
      if (k != 0) begin
        ref_v = {1'b0, pa} - {1'b0, pb} - {4'b0, pc};
        check_out("sweep", ref_v[3:0], ref_v[4], 1'b1);
      end
      pa = a; pb = b; pc = cin;
      @(negedge clk);
    end
    ref_v = {1'b0, pa} - {1'b0, pb} - {4'b0, pc};
    check_out("sweep_last", ref_v[3:0], ref_v[4], 1'b1);
    in_valid = 1'b0;

    @(negedge clk);
    check_out("sweep_idle", ref_v[3:0], ref_v[4], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
